// File: rtl/rainbow_light_monitor.sv
// ----------------------------------------------------------------------------
// rainbow_light_monitor
//
// Receive-side checker for the 8-bit rainbow light bus. Each valid sample of
// the LED pattern word is decoded as a Mode A fill/drain step, a Mode B
// alternation pattern, all-off, or illegal. The block locks onto the running
// sequence, predicts the next pattern and flags illegal transitions.
//
// Ports:
//   clk        in   1  single clock, all state on its rising edge
//   rst        in   1  asynchronous active-high reset
//   din        in   8  light pattern word
//   din_valid  in   1  sample strobe; din only looked at when high
//   mode       out  2  0 = hunting, 1 = Mode A, 2 = Mode B
//   step       out  4  Mode A step 0..15, or Mode B phase 0/1
//   locked     out  1  high while tracking Mode A or Mode B
//   err        out  1  one-cycle pulse on a mismatch while locked
//   err_cnt    out  8  saturating mismatch count
//   cycle_done out  1  one-cycle pulse on the Mode A 15 -> 0 wrap
//   mode_sw    out  1  one-cycle pulse on a legal Mode A <-> Mode B jump
//
// Parameter LOSS_LIMIT (1..15): consecutive mismatches that drop lock.
// ----------------------------------------------------------------------------
module rainbow_light_monitor #(
  parameter int unsigned LOSS_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic [1:0] mode,
  output logic [3:0] step,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic       cycle_done,
  output logic       mode_sw
);

  // State encoding doubles as the mode output value.
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    TRACK_A = 2'd1,
    TRACK_B = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DEC_A,
    DEC_ZERO,
    DEC_B0,
    DEC_B1,
    DEC_ILL
  } dec_t;

  localparam logic [4:0] LOSS_LIM = 5'(LOSS_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [3:0]  miss_q, miss_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        err_q, err_d;
  logic        cycle_done_q, cycle_done_d;
  logic        mode_sw_q, mode_sw_d;

  dec_t        dec_cls;
  logic [3:0]  dec_k;
  logic [7:0]  din_inv;
  logic [3:0]  step_inc;
  logic        mismatch;

  function automatic logic [3:0] ones(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Pattern decode. A fill step is a contiguous run of ones from bit 0
  // (x & (x+1) == 0); a drain step is a contiguous run of ones ending at
  // bit 7, i.e. its complement is a fill mask. The step index follows from
  // the number of lit LEDs.
  always_comb begin
    dec_cls = DEC_ILL;
    dec_k   = 4'd0;
    din_inv = ~din;
    if (din == 8'h00) begin
      dec_cls = DEC_ZERO;
    end else if (din == 8'h55) begin
      dec_cls = DEC_B0;
    end else if (din == 8'hAA) begin
      dec_cls = DEC_B1;
    end else if ((din & (din + 8'd1)) == 8'h00) begin
      dec_cls = DEC_A;
      dec_k   = ones(din) - 4'd1;
    end else if ((din_inv & (din_inv + 8'd1)) == 8'h00) begin
      dec_cls = DEC_A;
      dec_k   = 4'd15 - ones(din);
    end
  end

  // 4-bit wrap gives (step + 1) mod 16 for free.
  assign step_inc = step_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    miss_d       = miss_q;
    err_cnt_d    = err_cnt_q;
    err_d        = 1'b0;
    cycle_done_d = 1'b0;
    mode_sw_d    = 1'b0;
    mismatch     = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (dec_cls == DEC_A) begin
            state_d = TRACK_A;
            step_d  = dec_k;
          end else if (dec_cls == DEC_B0 || dec_cls == DEC_B1) begin
            state_d = TRACK_B;
            step_d  = {3'b000, dec_cls == DEC_B1};
          end
        end

        TRACK_A: begin
          // Step 15 is the all-off pattern, so ZERO is the match after 14.
          if ((dec_cls == DEC_A && dec_k == step_inc) ||
              (dec_cls == DEC_ZERO && step_inc == 4'd15)) begin
            step_d       = step_inc;
            miss_d       = 4'd0;
            cycle_done_d = (step_q == 4'd15);
          end else if (dec_cls == DEC_B0 || dec_cls == DEC_B1) begin
            state_d   = TRACK_B;
            step_d    = {3'b000, dec_cls == DEC_B1};
            miss_d    = 4'd0;
            mode_sw_d = 1'b1;
          end else begin
            mismatch = 1'b1;
            if (dec_cls == DEC_A) begin
              step_d = dec_k;
            end else if (dec_cls == DEC_ZERO) begin
              step_d = 4'd15;
            end
          end
        end

        TRACK_B: begin
          if ((dec_cls == DEC_B0 && step_q[0]) ||
              (dec_cls == DEC_B1 && !step_q[0])) begin
            step_d = step_q ^ 4'd1;
            miss_d = 4'd0;
          end else if (dec_cls == DEC_A) begin
            // A legal jump starts a fresh run, same as the A -> B direction.
            state_d   = TRACK_A;
            step_d    = dec_k;
            miss_d    = 4'd0;
            mode_sw_d = 1'b1;
          end else begin
            mismatch = 1'b1;
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase

      if (mismatch) begin
        err_d = 1'b1;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
        if (({1'b0, miss_q} + 5'd1) >= LOSS_LIM) begin
          state_d = HUNT;
          miss_d  = 4'd0;
        end else begin
          miss_d = miss_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      step_q       <= 4'd0;
      miss_q       <= 4'd0;
      err_cnt_q    <= 8'd0;
      err_q        <= 1'b0;
      cycle_done_q <= 1'b0;
      mode_sw_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      miss_q       <= miss_d;
      err_cnt_q    <= err_cnt_d;
      err_q        <= err_d;
      cycle_done_q <= cycle_done_d;
      mode_sw_q    <= mode_sw_d;
    end
  end

  assign mode       = state_q;
  assign step       = step_q;
  assign locked     = (state_q != HUNT);
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;
  assign cycle_done = cycle_done_q;
  assign mode_sw    = mode_sw_q;

endmodule

// File: tb/tb_rainbow_light_monitor.sv
// ----------------------------------------------------------------------------
// tb_rainbow_light_monitor
//
// Table-driven directed vectors, hand-written corner sequences (async reset,
// err_cnt saturation) and randomized traffic checked against a pattern-table
// reference model.
// ----------------------------------------------------------------------------
module tb_rainbow_light_monitor;

  localparam int LOSS = 3;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic [1:0] mode;
  logic [3:0] step;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic       cycle_done;
  logic       mode_sw;

  int total = 0;
  int bad   = 0;

  rainbow_light_monitor #(.LOSS_LIMIT(LOSS)) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .mode(mode),
    .step(step),
    .locked(locked),
    .err(err),
    .err_cnt(err_cnt),
    .cycle_done(cycle_done),
    .mode_sw(mode_sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Reference model: Mode A patterns come from a 16-entry table (entry 15 is
  // all-off); the model tracks mode/step/miss/err_cnt as plain integers.
  // --------------------------------------------------------------------------
  logic [7:0] pat_a [16];
  int m_mode, m_step, m_miss, m_ec;
  bit m_err, m_cd, m_msw;

  function automatic void model_reset();
    m_mode = 0; m_step = 0; m_miss = 0; m_ec = 0;
    m_err = 0; m_cd = 0; m_msw = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [7:0] d);
    int a_idx;
    int b_idx;
    int nxt;
    bit mm;
    m_err = 0; m_cd = 0; m_msw = 0;
    if (!v) return;
    a_idx = -1;
    for (int k = 0; k < 15; k++) if (pat_a[k] == d) a_idx = k;
    b_idx = (d == 8'h55) ? 0 : (d == 8'hAA) ? 1 : -1;
    mm = 0;
    if (m_mode == 0) begin
      if (a_idx >= 0) begin m_mode = 1; m_step = a_idx; end
      else if (b_idx >= 0) begin m_mode = 2; m_step = b_idx; end
    end else if (m_mode == 1) begin
      nxt = (m_step + 1) % 16;
      if (pat_a[nxt] == d) begin
        m_cd = (m_step == 15); m_step = nxt; m_miss = 0;
      end else if (b_idx >= 0) begin
        m_mode = 2; m_step = b_idx; m_miss = 0; m_msw = 1;
      end else begin
        mm = 1;
        if (a_idx >= 0) m_step = a_idx;
        else if (d == 8'h00) m_step = 15;
      end
    end else begin
      if (b_idx >= 0 && b_idx != m_step) begin
        m_step = b_idx; m_miss = 0;
      end else if (a_idx >= 0) begin
        m_mode = 1; m_step = a_idx; m_miss = 0; m_msw = 1;
      end else begin
        mm = 1;
      end
    end
    if (mm) begin
      m_err = 1;
      if (m_ec < 255) m_ec++;
      m_miss++;
      if (m_miss >= LOSS) begin m_mode = 0; m_miss = 0; end
    end
  endfunction

  function automatic logic [17:0] model_vec();
    return {2'(m_mode), 4'(m_step), 1'(m_mode != 0), m_err, 8'(m_ec), m_cd, m_msw};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {mode, step, locked, err, err_cnt, cycle_done, mode_sw};
  endfunction

  function automatic string fmt(input logic [17:0] o);
    return $sformatf("mode=%0d step=%0d locked=%0b err=%0b err_cnt=%0d cycle_done=%0b mode_sw=%0b",
                     o[17:16], o[15:12], o[11], o[10], o[9:2], o[1], o[0]);
  endfunction

  task automatic cmp(input string name, input logic [17:0] got, input logic [17:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %s, want %s", name, fmt(got), fmt(want));
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] d);
    @(negedge clk);
    din_valid = v;
    din       = d;
    @(posedge clk);
    #1;
    model_step(v, d);
    cmp("model", dut_vec(), model_vec());
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst       = 1'b1;
    din_valid = 1'b0;
    #1;
    cmp("reset_state", dut_vec(), 18'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    bit         do_rst;
    bit         v;
    logic [7:0] d;
    logic [1:0] mode;
    logic [3:0] step;
    bit         locked;
    bit         err;
    logic [7:0] ec;
    bit         cd;
    bit         msw;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input bit r, input bit v, input logic [7:0] d,
                              input logic [1:0] md, input logic [3:0] st, input bit lk,
                              input bit e, input logic [7:0] ec, input bit cd, input bit msw);
    vec_t x;
    x.do_rst = r; x.v = v; x.d = d; x.mode = md; x.step = st; x.locked = lk;
    x.err = e; x.ec = ec; x.cd = cd; x.msw = msw;
    vt.push_back(x);
  endfunction

  initial begin
    logic [7:0] rd;
    int r;
    int b;

    rst = 1'b1; din = 8'h00; din_valid = 1'b0;
    for (int k = 0; k < 8; k++) pat_a[k] = 8'((16'd1 << (k + 1)) - 16'd1);
    for (int k = 8; k < 15; k++) pat_a[k] = 8'(8'hFF << (k - 7));
    pat_a[15] = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);

    // Full Mode A sequence, wrap through all-off and back to step 0.
    for (int k = 0; k < 15; k++) add(k == 0, 1, pat_a[k], 1, 4'(k), 1, 0, 0, 0, 0);
    add(0, 1, 8'h00, 1, 15, 1, 0, 0, 0, 0);
    add(0, 1, 8'h01, 1, 0, 1, 0, 0, 1, 0);
    // Mode B alternation from reset; all-off keeps hunting.
    add(1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      add(0, 1, 8'h55, 2, 0, 1, 0, 0, 0, 0);
      add(0, 1, 8'hAA, 2, 1, 1, 0, 0, 0, 0);
    end
    // Mode switch A(5) -> B1 -> A5.
    for (int k = 0; k < 6; k++) add(k == 0, 1, pat_a[k], 1, 4'(k), 1, 0, 0, 0, 0);
    add(0, 1, 8'hAA, 2, 1, 1, 0, 0, 0, 1);
    add(0, 1, 8'h3F, 1, 5, 1, 0, 0, 0, 1);
    // Lock loss in Mode B.
    add(1, 1, 8'h55, 2, 0, 1, 0, 0, 0, 0);
    add(0, 1, 8'h33, 2, 0, 1, 1, 1, 0, 0);
    add(0, 1, 8'h33, 2, 0, 1, 1, 2, 0, 0);
    add(0, 1, 8'h33, 0, 0, 0, 1, 3, 0, 0);
    // Strobe gating, then a matching step, then a resync.
    for (int k = 0; k < 4; k++) add(k == 0, 1, pat_a[k], 1, 4'(k), 1, 0, 0, 0, 0);
    add(0, 0, 8'h5A, 1, 3, 1, 0, 0, 0, 0);
    add(0, 0, 8'h33, 1, 3, 1, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 3, 1, 0, 0, 0, 0);
    add(0, 0, 8'hAA, 1, 3, 1, 0, 0, 0, 0);
    add(0, 0, 8'hC3, 1, 3, 1, 0, 0, 0, 0);
    add(0, 1, 8'h1F, 1, 4, 1, 0, 0, 0, 0);
    add(0, 1, 8'hF0, 1, 11, 1, 1, 1, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].do_rst) apply_reset();
      drive(vt[i].v, vt[i].d);
      $display("vec %0d: valid=%0b din=%08b -> %s", i, vt[i].v, vt[i].d, fmt(dut_vec()));
      cmp($sformatf("vec%0d", i), dut_vec(),
          {vt[i].mode, vt[i].step, vt[i].locked, vt[i].err, vt[i].ec, vt[i].cd, vt[i].msw});
    end

    // Async reset between edges while an err pulse is showing in TRACK_A.
    apply_reset();
    drive(1, 8'h01);
    drive(1, 8'h03);
    drive(1, 8'h66);
    #2;
    rst = 1'b1;
    #1;
    cmp("async_reset", dut_vec(), 18'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(1, 8'h00);
    cmp("post_reset_zero", dut_vec(), 18'd0);

    // err_cnt saturation: two mismatches then a match, repeated.
    apply_reset();
    drive(1, 8'h01);
    for (int i = 0; i < 140; i++) begin
      drive(1, 8'h66);
      drive(1, 8'h66);
      drive(1, pat_a[(m_step + 1) % 16]);
    end
    drive(1, 8'h66);
    cmp("err_cnt_sat", {10'd0, err, err_cnt}, {10'd0, 1'b1, 8'hFF});

    // Randomized traffic against the model.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      rd = pat_a[(m_step + 1) % 16];
      else if (r < 60) rd = pat_a[$urandom_range(0, 15)];
      else if (r < 75) begin
        b  = (m_mode == 2 && $urandom_range(0, 3) != 0) ? 1 - m_step : $urandom_range(0, 1);
        rd = (b == 0) ? 8'h55 : 8'hAA;
      end
      else if (r < 82) rd = 8'h00;
      else             rd = 8'($urandom());
      drive($urandom_range(0, 9) != 0, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
